delay_search_ctrl: RTL and testbench
====================================

Name: delay_search_ctrl

Overview:
Alignment controller for the receive path. It sweeps the sample-phase delay (config_sam_delay.delay) and the symbol delay (config_sym_delay / config_data_delay.delay) over a configured window. For each candidate it measures the accumulated squared error from err_sq_gen over one full LFSR period, then programs the minimum-error pair and reports lock. It sits between lfsr_gen_max / err_sq_gen and the delay blocks, replacing the hard-coded delays.

Parameters:
SYM_MIN, 8'd32, first symbol delay tried
SYM_MAX, 8'd44, last symbol delay tried (inclusive, ≥ SYM_MIN)
SETTLE_CYCLES, 2, LFSR periods discarded after each delay change (range 1..15)
ERR_W, 18, width of acc_sq_err
LOCK_THRESH, 18'h00800, best error must be strictly below this value for locked=1

Ports:
clk  in  1  system clock (sys_clk)
reset  in  1  synchronous, active-high
sym_clk_en  in  1  symbol-rate enable
start  in  1  pulse: begin a sweep (ignored while busy)
cycle_done  in  1  LFSR period marker (cycle_out_periodic); used only on sym_clk_en cycles
acc_sq_err  in  ERR_W  held accumulated squared error, unsigned magnitude
sam_delay  out  2  to config_sam_delay.delay
sym_delay  out  8  to config_sym_delay and config_data_delay.delay
busy  out  1  sweep in progress
done  out  1  one-clk pulse at sweep completion
locked  out  1  result valid and best_err < LOCK_THRESH
best_err  out  ERR_W  minimum error found
best_sam  out  2  sam delay of best_err
best_sym  out  8  sym delay of best_err

Behaviour:
- Reset (sync, same edge): state=IDLE; sam_delay=2'd2, sym_delay=8'd38 (gold defaults); busy=0, done=0, locked=0; best_err=all ones; best_sam=0, best_sym=0. Reset mid-sweep aborts immediately to these values.
- Event "period" = cycle_done & sym_clk_en in the same clk.
- FSM:
  - IDLE: on start → APPLY. Set candidate sam=0, sym=SYM_MIN; best_err=all ones; locked=0; busy=1.
  - APPLY: drive sam_delay/sym_delay = candidate; clear settle counter; → SETTLE next clk.
  - SETTLE: count periods; after SETTLE_CYCLES periods → MEASURE.
  - MEASURE: on the next period → SAMPLE.
  - SAMPLE: wait for the next sym_clk_en, on which acc_sq_err holds the just-finished period's total (one-symbol lag of err_sq_gen). On that cycle, if acc_sq_err < best_err (strict), load best_err/best_sam/best_sym. → ADVANCE.
  - ADVANCE (1 clk): sam increments 0..3. On sam wrap, sam=0 and sym increments. If sym==SYM_MAX and sam==3 → FINAL, else → APPLY.
  - FINAL: sam_delay=best_sam, sym_delay=best_sym; locked=(best_err<LOCK_THRESH); done=1 for one clk; busy=0; → IDLE.
- Sweep order: sam inner, sym outer. Ties keep the earliest candidate.
- Total candidates: 4*(SYM_MAX-SYM_MIN+1). Each costs SETTLE_CYCLES+1 periods plus ~1 symbol.
- Outputs are registered, with no combinational path from inputs to outputs.
- start while busy: ignored. start in the same clk as done: ignored; a new sweep needs start while IDLE.
- cycle_done without sym_clk_en: ignored.
- Comparison is unsigned, full ERR_W width. An all-ones error never replaces the initial best.
- If every candidate reads all ones: FINAL programs best_sam=0, best_sym=0 and sets locked=0.
- In IDLE, delay outputs hold their last programmed values.

Decomposition:
- Shared package/defines header: FSM state encoding (IDLE, APPLY, SETTLE, MEASURE, SAMPLE, ADVANCE, FINAL), the gold default delays (2, 38), ERR_W.
- Sub-module: delay_cand_counter. Holds the sam/sym candidate registers, increment and wrap logic, and the last-candidate flag. The FSM drives its load and advance inputs.

Test Plan:
1. Reset mid-sweep (assert during SETTLE of 3rd candidate) → next clk busy=0, sam_delay=2, sym_delay=38, locked=0, best_err=18'h3FFFF.
2. Behavioural err model err=|sym-38|*1000+|sam-2|*100, SYM 32..44 → done pulses once; best_sym=38, best_sam=2, best_err=0, locked=1, outputs 2/38.
3. Model returns constant 18'h01000 for all candidates → ties keep first: best_sam=0, best_sym=32, locked=0 (not < LOCK_THRESH).
4. Count periods from start to done, SETTLE_CYCLES=2, 13 sym values → exactly 52*3=156 periods; sam_delay never changes outside APPLY/FINAL.
5. start pulsed repeatedly during sweep, and cycle_done asserted without sym_clk_en → no restart, no extra period counted; result identical to scenario 2.
6. Model min at edge (sym=44, sam=3, err=5; others ≥1000) → best_sym=44, best_sam=3, best_err=5, locked=1; a second start re-sweeps and reproduces the same result.

Source files
------------

// File: rtl/delay_search_ctrl_pkg.sv
// delay_search_ctrl_pkg: shared FSM encoding and gold default delays
package delay_search_ctrl_pkg;
  typedef enum logic [2:0] {IDLE, APPLY, SETTLE, MEASURE, SAMPLE, ADVANCE, FINAL} state_t;
  localparam logic [1:0] GOLD_SAM = 2'd2;
  localparam logic [7:0] GOLD_SYM = 8'd38;
  localparam int ERR_W_DEF = 18;
endpackage

// File: rtl/delay_cand_counter.sv
// delay_cand_counter: sam (inner) / sym (outer) candidate sweep registers
module delay_cand_counter #(
  parameter logic [7:0] SYM_MIN = 8'd32,
  parameter logic [7:0] SYM_MAX = 8'd44
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       load,
  input  logic       advance,
  output logic [1:0] sam,
  output logic [7:0] sym,
  output logic       last
);
  always_ff @(posedge clk)
    if (reset || load) begin
      sam <= '0;
      sym <= SYM_MIN;
    end else if (advance) begin
      sam <= sam + 2'd1;
      if (sam == 2'd3) sym <= sym + 8'd1;
    end
  assign last = (sym == SYM_MAX) && (sam == 2'd3);
endmodule

// File: rtl/delay_search_ctrl.sv
// delay_search_ctrl: sweeps sam/sym delays, keeps the minimum-error pair and reports lock
module delay_search_ctrl
  import delay_search_ctrl_pkg::*;
#(
  parameter logic [7:0] SYM_MIN = 8'd32,
  parameter logic [7:0] SYM_MAX = 8'd44,
  parameter int SETTLE_CYCLES = 2,
  parameter int ERR_W = ERR_W_DEF,
  parameter logic [ERR_W-1:0] LOCK_THRESH = 'h00800
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             sym_clk_en,
  input  logic             start,
  input  logic             cycle_done,
  input  logic [ERR_W-1:0] acc_sq_err,
  output logic [1:0]       sam_delay,
  output logic [7:0]       sym_delay,
  output logic             busy,
  output logic             done,
  output logic             locked,
  output logic [ERR_W-1:0] best_err,
  output logic [1:0]       best_sam,
  output logic [7:0]       best_sym
);
  localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES - 1);
  state_t state, state_n;
  logic [3:0] settle_cnt, settle_cnt_n;
  logic [1:0] cand_sam, sam_delay_n, best_sam_n;
  logic [7:0] cand_sym, sym_delay_n, best_sym_n;
  logic [ERR_W-1:0] best_err_n;
  logic cand_last, cand_load, cand_adv, busy_n, done_n, locked_n;
  logic period;
  assign period = cycle_done & sym_clk_en;
  delay_cand_counter #(.SYM_MIN(SYM_MIN), .SYM_MAX(SYM_MAX)) u_cand (
    .clk(clk), .reset(reset), .load(cand_load), .advance(cand_adv),
    .sam(cand_sam), .sym(cand_sym), .last(cand_last)
  );
  always_comb begin
    state_n = state;
    settle_cnt_n = settle_cnt;
    sam_delay_n = sam_delay;
    sym_delay_n = sym_delay;
    busy_n = busy;
    done_n = 1'b0;
    locked_n = locked;
    best_err_n = best_err;
    best_sam_n = best_sam;
    best_sym_n = best_sym;
    cand_load = 1'b0;
    cand_adv = 1'b0;
    case (state)
      IDLE: if (start && !done) begin
        state_n = APPLY;
        cand_load = 1'b1;
        best_err_n = '1;
        best_sam_n = '0;
        best_sym_n = '0;
        locked_n = 1'b0;
        busy_n = 1'b1;
      end
      APPLY: begin
        sam_delay_n = cand_sam;
        sym_delay_n = cand_sym;
        settle_cnt_n = '0;
        state_n = SETTLE;
      end
      SETTLE: if (period) begin
        settle_cnt_n = settle_cnt + 4'd1;
        state_n = (settle_cnt == SETTLE_LAST) ? MEASURE : SETTLE;
      end
      MEASURE: state_n = period ? SAMPLE : MEASURE;
      // acc_sq_err lags err_sq_gen by one symbol, so the finished total is valid on the next enable
      SAMPLE: if (sym_clk_en) begin
        if (acc_sq_err < best_err) begin
          best_err_n = acc_sq_err;
          best_sam_n = sam_delay;
          best_sym_n = sym_delay;
        end
        state_n = ADVANCE;
      end
      ADVANCE: begin
        cand_adv = !cand_last;
        state_n = cand_last ? FINAL : APPLY;
      end
      FINAL: begin
        sam_delay_n = best_sam;
        sym_delay_n = best_sym;
        locked_n = best_err < LOCK_THRESH;
        done_n = 1'b1;
        busy_n = 1'b0;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk)
    if (reset) begin
      state <= IDLE;
      settle_cnt <= '0;
      sam_delay <= GOLD_SAM;
      sym_delay <= GOLD_SYM;
      busy <= 1'b0;
      done <= 1'b0;
      locked <= 1'b0;
      best_err <= '1;
      best_sam <= '0;
      best_sym <= '0;
    end else begin
      state <= state_n;
      settle_cnt <= settle_cnt_n;
      sam_delay <= sam_delay_n;
      sym_delay <= sym_delay_n;
      busy <= busy_n;
      done <= done_n;
      locked <= locked_n;
      best_err <= best_err_n;
      best_sam <= best_sam_n;
      best_sym <= best_sym_n;
    end
endmodule

// File: tb/tb_delay_search_ctrl.sv
// tb_delay_search_ctrl: directed sweeps against a behavioural error plant
module tb_delay_search_ctrl;
  logic clk = 1'b0, reset = 1'b1, sym_clk_en = 1'b0, start = 1'b0, cycle_done = 1'b0;
  logic [17:0] acc_sq_err, best_err;
  logic [1:0] sam_delay, best_sam, last_sam;
  logic [7:0] sym_delay, best_sym, last_sym;
  logic busy, done, locked;
  int mode = 0, ph = 0, periods = 0, sam_chg = 0, sym_chg = 0, n_chk = 0, n_fail = 0;
  bit noise = 0, counting = 0;
  delay_search_ctrl dut (
    .clk(clk), .reset(reset), .sym_clk_en(sym_clk_en), .start(start), .cycle_done(cycle_done),
    .acc_sq_err(acc_sq_err), .sam_delay(sam_delay), .sym_delay(sym_delay), .busy(busy),
    .done(done), .locked(locked), .best_err(best_err), .best_sam(best_sam), .best_sym(best_sym)
  );
  always #5 clk = ~clk;
  function automatic logic [17:0] err_model(input int m, input logic [1:0] s, input logic [7:0] y);
    int ds, dy;
    ds = int'(s) - 2;
    dy = int'(y) - 38;
    if (ds < 0) ds = -ds;
    if (dy < 0) dy = -dy;
    case (m)
      0: return 18'(dy * 1000 + ds * 100);
      1: return 18'h01000;
      2: return (y == 8'd44 && s == 2'd3) ? 18'd5 : 18'(1000 + dy * 10);
      default: return '1;
    endcase
  endfunction
  assign acc_sq_err = err_model(mode, sam_delay, sym_delay);
  // symbol enable every other clk, LFSR period every third symbol; noise adds a cycle_done with no enable
  initial forever begin
    @(posedge clk);
    #1;
    ph = (ph == 5) ? 0 : ph + 1;
    sym_clk_en = (ph % 2 == 1);
    cycle_done = (ph == 5) || (noise && ph == 2);
  end
  always @(posedge clk) if (counting && cycle_done && sym_clk_en) periods++;
  always @(negedge clk) begin
    if (counting && sam_delay != last_sam) sam_chg++;
    if (counting && sym_delay != last_sym) sym_chg++;
    last_sam = sam_delay;
    last_sym = sym_delay;
  end
  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask
  task automatic kick();
    while (ph != 5) @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #2;
    start = 1'b0;
  endtask
  task automatic run_sweep(input bit spam);
    bit got = 0;
    kick();
    periods = 0;
    sam_chg = 0;
    sym_chg = 0;
    counting = 1;
    check("busy_on", busy, 1);
    for (int i = 0; i < 5000 && !got; i++) begin
      @(negedge clk);
      #1;
      if (done) got = 1;
      else if (spam) start = (i % 5 == 0);
    end
    counting = 0;
    check("done_seen", got, 1);
    start = 1'b1;
    @(negedge clk);
    #1;
    start = 1'b0;
    check("done_one_clk", done, 0);
    check("start_at_done_ignored", busy, 0);
  endtask
  task automatic check_result(input string tag, input logic [17:0] e, input logic [1:0] s,
                              input logic [7:0] y, input logic l);
    check({tag, "_best_err"}, best_err, e);
    check({tag, "_best_sam"}, best_sam, s);
    check({tag, "_best_sym"}, best_sym, y);
    check({tag, "_locked"}, locked, l);
    check({tag, "_sam_delay"}, sam_delay, s);
    check({tag, "_sym_delay"}, sym_delay, y);
  endtask
  initial begin
    bit hit = 0;
    repeat (3) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_locked", locked, 0);
    check("rst_sam", sam_delay, 2);
    check("rst_sym", sym_delay, 38);
    check("rst_best_err", best_err, 18'h3FFFF);
    check("rst_best_pair", {best_sam, best_sym}, 0);
    reset = 1'b0;
    kick();
    for (int i = 0; i < 500 && !hit; i++) begin
      @(negedge clk);
      hit = (sam_delay == 2'd2 && sym_delay == 8'd32);
    end
    check("third_cand_reached", hit, 1);
    check("mid_best_err", best_err, 6100);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("abort_busy", busy, 0);
    check("abort_sam", sam_delay, 2);
    check("abort_sym", sym_delay, 38);
    check("abort_locked", locked, 0);
    check("abort_best_err", best_err, 18'h3FFFF);
    run_sweep(0);
    check_result("bowl", 0, 2, 38, 1);
    check("bowl_periods", periods, 156);
    check("bowl_sam_changes", sam_chg, 53);
    check("bowl_sym_changes", sym_chg, 14);
    noise = 1;
    run_sweep(1);
    noise = 0;
    check_result("noisy", 0, 2, 38, 1);
    check("noisy_periods", periods, 156);
    mode = 1;
    run_sweep(0);
    check_result("tie", 18'h01000, 0, 32, 0);
    mode = 2;
    run_sweep(0);
    check_result("edge1", 5, 3, 44, 1);
    run_sweep(0);
    check_result("edge2", 5, 3, 44, 1);
    mode = 3;
    run_sweep(0);
    check_result("ones", 18'h3FFFF, 0, 0, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
